vga_sync_decoder: RTL and testbench
===================================

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 SHALL have parameter H_TOTAL, default 800, expected strobes per line.
REQ-002 SHALL have parameter V_TOTAL, default 525, expected lines per frame.
REQ-003 SHALL have parameter H_OFFSET, default 144, strobes from hsync leading edge to first active pixel.
REQ-004 SHALL have parameter V_OFFSET, default 35, lines from vsync leading edge to first active line.
REQ-005 SHALL have parameter H_ACTIVE, default 640, and parameter V_ACTIVE, default 480, as the active pixel and line counts.
REQ-006 SHALL have parameter SYNC_POL, default 0, giving the sync asserted level (0 = active-low).
REQ-007 SHALL have port i_clk, input, 1, the single system clock.
REQ-008 SHALL have port i_rst, input, 1, reset; one clock, reset is synchronous and active-high.
REQ-009 SHALL have port i_pix_stb, input, 1, pixel strobe; the block samples inputs only on clocks where it is high.
REQ-010 SHALL have port i_hs, input, 1, incoming horizontal sync.
REQ-011 SHALL have port i_vs, input, 1, incoming vertical sync.
REQ-012 SHALL have port o_x, output, 10, recovered pixel column.
REQ-013 SHALL have port o_y, output, 9, recovered pixel row.
REQ-014 SHALL have port o_de, output, 1, high while the recovered position is active and the block is locked.
REQ-015 SHALL have port o_frame, output, 1, one-clock pulse at each vsync leading edge while locked.
REQ-016 SHALL have port o_locked, output, 1, timing lock indication.
REQ-017 SHALL have port o_h_total, output, 11, last measured line length in strobes.
REQ-018 SHALL have port o_v_total, output, 10, last measured frame length in lines.

Function
REQ-019 SHALL register i_hs/i_vs on each strobe; leading edge = sample equals SYNC_POL and previous sample does not.
REQ-020 SHALL clear h_pos (11 bits) on a strobe with hs edge, else increment per strobe, saturating at 2047.
REQ-021 SHALL clear v_pos (10 bits) on a strobe with vs edge, else increment on each hs edge, saturating at 1023; clear wins when both edges coincide.
REQ-022 SHALL on each hs edge latch o_h_total = h_pos+1 (pre-clear value), except the first hs edge after reset or unlock.
REQ-023 SHALL on each vs edge latch o_v_total = v_pos (pre-clear value), except the first vs edge after reset or unlock.
REQ-024 SHALL set o_de when locked, h_pos in [H_OFFSET, H_OFFSET+H_ACTIVE-1] and v_pos in [V_OFFSET, V_OFFSET+V_ACTIVE-1]; o_x = h_pos-H_OFFSET, o_y = v_pos-V_OFFSET when o_de, else both 0.
REQ-025 SHALL register all outputs; a strobe at cycle N is reflected on outputs at cycle N+1; outputs hold between strobes.
REQ-026 SHALL implement lock FSM UNLOCKED, ACQUIRE, LOCKED; o_locked high only in LOCKED.
REQ-027 UNLOCKED SHALL move to ACQUIRE on a vs edge, clearing the good-frame count and line-error flag.
REQ-028 ACQUIRE SHALL set line-error on any measured line != H_TOTAL; at each vs edge, a frame with v_total == V_TOTAL and no line-error increments good-frame count, else returns to UNLOCKED.
REQ-029 ACQUIRE SHALL move to LOCKED on the vs edge completing the second consecutive good frame.
REQ-030 LOCKED SHALL return to UNLOCKED at once on any measured line != H_TOTAL, frame != V_TOTAL, or h_pos reaching 2*H_TOTAL (lost hsync).
REQ-031 Unlock SHALL drop o_locked, o_de, o_frame in the same output update; o_h_total/o_v_total keep their last values.

Reset
REQ-032 On i_rst: FSM = UNLOCKED, h_pos = v_pos = 0, sync history = deasserted, o_x = o_y = 0, o_de = o_frame = o_locked = 0, o_h_total = o_v_total = 0.
REQ-033 Reset mid-frame SHALL discard all measurement state; reacquisition requires a fresh vs edge plus two good frames.

Verification
REQ-034 Standard 640x480 syncs, strobe every 4th clock -> o_locked rises at 3rd vs edge; o_h_total=800, o_v_total=525; o_de covers exactly 640x480 per frame.
REQ-035 Locked; check first active pixel -> o_x=0, o_y=0, o_de=1 one clock after strobe at h_pos=144, v_pos=35; last pixel o_x=639, o_y=479.
REQ-036 Locked; one line shortened to 799 strobes -> o_locked=0 after that hs edge; o_h_total=799; relock after two clean frames.
REQ-037 Locked; hsync held deasserted -> o_locked=0 when h_pos reaches 1600; o_de=0 thereafter.
REQ-038 hs and vs leading edges on same strobe -> v_pos=0, no increment; assert i_rst mid-frame -> all outputs zero next clock.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel position and timing lock from incoming sync pulses.
// Ports:
//   i_clk, i_rst              - system clock, synchronous active-high reset
//   i_pix_stb                 - pixel strobe; inputs are sampled only when high
//   i_hs, i_vs                - incoming horizontal / vertical sync (asserted level SYNC_POL)
//   o_x, o_y, o_de            - recovered active pixel column/row and data enable
//   o_frame                   - one-clock pulse at each vsync leading edge while locked
//   o_locked                  - timing lock indication
//   o_h_total, o_v_total      - last measured line length (strobes) / frame length (lines)
module vga_sync_decoder #(
    parameter int unsigned H_TOTAL  = 800,
    parameter int unsigned V_TOTAL  = 525,
    parameter int unsigned H_OFFSET = 144,
    parameter int unsigned V_OFFSET = 35,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pix_stb,
    input  logic        i_hs,
    input  logic        i_vs,
    output logic [9:0]  o_x,
    output logic [8:0]  o_y,
    output logic        o_de,
    output logic        o_frame,
    output logic        o_locked,
    output logic [10:0] o_h_total,
    output logic [9:0]  o_v_total
);

    localparam int unsigned HW  = 11;
    localparam int unsigned HLW = HW + 1;
    localparam int unsigned VW  = 10;
    localparam int unsigned VLW = VW + 1;
    localparam int unsigned XW  = 10;
    localparam int unsigned YW  = 9;
    localparam logic [HW-1:0] H_MAX = '1;
    localparam logic [VW-1:0] V_MAX = '1;

    typedef enum logic [1:0] {ST_UNLOCKED, ST_ACQUIRE, ST_LOCKED} state_t;

    state_t        state, state_nxt;
    logic          hs_q, vs_q;
    logic [HW-1:0] h_pos, h_pos_nxt;
    logic [VW-1:0] v_pos, v_pos_nxt;
    logic          h_seen, v_seen;
    logic          good_cnt, good_nxt;
    logic          line_err, line_err_nxt;

    logic           hs_edge_c, vs_edge_c;
    logic [HLW-1:0] h_len_c;
    logic           h_bad_c, v_bad_c, lost_c;
    logic           locked_nxt_c, de_nxt_c, unlock_c;

    // Leading edges: current sample asserted, previous strobe's sample not
    assign hs_edge_c = i_pix_stb && (i_hs == SYNC_POL) && (hs_q != SYNC_POL);
    assign vs_edge_c = i_pix_stb && (i_vs == SYNC_POL) && (vs_q != SYNC_POL);

    // Line length seen at an hs edge; only a measurement once a previous hs edge anchored h_pos
    assign h_len_c = {1'b0, h_pos} + HLW'(1);
    assign h_bad_c = hs_edge_c && h_seen && (h_len_c != HLW'(H_TOTAL));
    assign v_bad_c = (v_pos != VW'(V_TOTAL));

    // Position counters: sync edge clears, otherwise saturating increment
    always_comb begin
        h_pos_nxt = h_pos;
        v_pos_nxt = v_pos;
        if (i_pix_stb) begin
            if (hs_edge_c)
                h_pos_nxt = '0;
            else if (h_pos != H_MAX)
                h_pos_nxt = h_pos + HW'(1);
            if (vs_edge_c)
                v_pos_nxt = '0;
            else if (hs_edge_c && (v_pos != V_MAX))
                v_pos_nxt = v_pos + VW'(1);
        end
    end

    // Two missing line periods means hsync has gone away
    assign lost_c = i_pix_stb && ({1'b0, h_pos_nxt} == HLW'(2 * H_TOTAL));

    // Lock FSM next state
    always_comb begin
        state_nxt    = state;
        good_nxt     = good_cnt;
        line_err_nxt = line_err;
        unique case (state)
            ST_UNLOCKED: begin
                if (vs_edge_c) begin
                    state_nxt    = ST_ACQUIRE;
                    good_nxt     = 1'b0;
                    line_err_nxt = 1'b0;
                end
            end
            ST_ACQUIRE: begin
                if (h_bad_c)
                    line_err_nxt = 1'b1;
                if (vs_edge_c) begin
                    if (v_seen && !v_bad_c && !line_err_nxt) begin
                        if (good_cnt)
                            state_nxt = ST_LOCKED;
                        else
                            good_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_UNLOCKED;
                    end
                    line_err_nxt = 1'b0;
                end
            end
            ST_LOCKED: begin
                if (h_bad_c || (vs_edge_c && v_bad_c) || lost_c)
                    state_nxt = ST_UNLOCKED;
            end
            default: state_nxt = ST_UNLOCKED;
        endcase
    end

    assign unlock_c     = (state == ST_LOCKED) && (state_nxt == ST_UNLOCKED);
    assign locked_nxt_c = (state_nxt == ST_LOCKED);
    assign de_nxt_c     = locked_nxt_c
                       && ({1'b0, h_pos_nxt} >= HLW'(H_OFFSET))
                       && ({1'b0, h_pos_nxt} <  HLW'(H_OFFSET + H_ACTIVE))
                       && ({1'b0, v_pos_nxt} >= VLW'(V_OFFSET))
                       && ({1'b0, v_pos_nxt} <  VLW'(V_OFFSET + V_ACTIVE));

    // Lock FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst)
            state <= ST_UNLOCKED;
        else
            state <= state_nxt;
    end

    // Sync history, counters, measurements and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hs_q      <= ~SYNC_POL;
            vs_q      <= ~SYNC_POL;
            h_pos     <= '0;
            v_pos     <= '0;
            h_seen    <= 1'b0;
            v_seen    <= 1'b0;
            good_cnt  <= 1'b0;
            line_err  <= 1'b0;
            o_x       <= '0;
            o_y       <= '0;
            o_de      <= 1'b0;
            o_frame   <= 1'b0;
            o_locked  <= 1'b0;
            o_h_total <= '0;
            o_v_total <= '0;
        end else begin
            good_cnt <= good_nxt;
            line_err <= line_err_nxt;
            o_frame  <= vs_edge_c && locked_nxt_c;
            if (i_pix_stb) begin
                hs_q     <= i_hs;
                vs_q     <= i_vs;
                h_pos    <= h_pos_nxt;
                v_pos    <= v_pos_nxt;
                o_locked <= locked_nxt_c;
                o_de     <= de_nxt_c;
                o_x      <= de_nxt_c ? XW'(h_pos_nxt - HW'(H_OFFSET)) : '0;
                o_y      <= de_nxt_c ? YW'(v_pos_nxt - VW'(V_OFFSET)) : '0;
                if (hs_edge_c) begin
                    h_seen <= 1'b1;
                    if (h_seen)
                        o_h_total <= HW'(h_len_c);
                end
                if (vs_edge_c) begin
                    v_seen <= 1'b1;
                    if (v_seen)
                        o_v_total <= v_pos;
                end
            end
            // Losing lock restarts measurement; the next edges only re-anchor
            if (unlock_c) begin
                h_seen <= 1'b0;
                v_seen <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed bench using a reduced 20x12 raster, strobe every 4th clock.
module tb_vga_sync_decoder;

    localparam int unsigned HT = 20;
    localparam int unsigned VT = 12;
    localparam int unsigned HO = 5;
    localparam int unsigned VO = 3;
    localparam int unsigned HA = 12;
    localparam int unsigned VA = 6;
    localparam logic        POL = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic        hs;
    logic        vs;
    logic [9:0]  o_x;
    logic [8:0]  o_y;
    logic        o_de;
    logic        o_frame;
    logic        o_locked;
    logic [10:0] o_h_total;
    logic [9:0]  o_v_total;

    int n_checks = 0;
    int n_fail   = 0;

    // Generator position (frame, line, strobe) and the position of the last strobe sent
    int gf, gy, gx;
    int last_f, last_y, last_x;
    int de_cnt, xy_err;

    vga_sync_decoder #(
        .H_TOTAL (HT),
        .V_TOTAL (VT),
        .H_OFFSET(HO),
        .V_OFFSET(VO),
        .H_ACTIVE(HA),
        .V_ACTIVE(VA),
        .SYNC_POL(POL)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_pix_stb(stb),
        .i_hs     (hs),
        .i_vs     (vs),
        .o_x      (o_x),
        .o_y      (o_y),
        .o_de     (o_de),
        .o_frame  (o_frame),
        .o_locked (o_locked),
        .o_h_total(o_h_total),
        .o_v_total(o_v_total)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Three idle clocks then one strobe clock; returns after the strobe's output update
    task automatic do_strobe(input logic h, input logic v);
        repeat (3) @(negedge clk);
        stb = 1'b1;
        hs  = h;
        vs  = v;
        @(negedge clk);
        stb = 1'b0;
    endtask

    // One raster strobe: frame 3 has an extra line, frame 4 has vsync coincident with hsync,
    // frame 5 line 5 is one strobe short, frame 8 loses hsync from line 4 onward
    task automatic gen_strobe();
        int   len, lines, f, vs0;
        logic ha, va;
        len   = (gf == 5 && gy == 5) ? HT - 1 : HT;
        lines = (gf == 3) ? VT + 1 : VT;
        vs0   = (gf == 4) ? 0 : 1;
        f     = gy * HT + gx;
        ha    = (gx < 2) && !(gf == 8 && gy >= 4);
        va    = (f >= vs0) && (f < vs0 + 2 * HT);
        do_strobe(ha ? POL : ~POL, va ? POL : ~POL);
        last_f = gf;
        last_y = gy;
        last_x = gx;
        if (o_de) begin
            de_cnt++;
            if (gx < HO || gx >= HO + HA || gy < VO || gy >= VO + VA ||
                int'(o_x) != gx - HO || int'(o_y) != gy - VO)
                xy_err++;
        end
        gx++;
        if (gx == len) begin
            gx = 0;
            gy++;
            if (gy == lines) begin
                gy = 0;
                gf++;
            end
        end
    endtask

    task automatic run_to(input int f, input int y, input int x);
        int guard;
        guard = 0;
        while (!(last_f == f && last_y == y && last_x == x) && guard < 20000) begin
            gen_strobe();
            guard++;
        end
        if (guard >= 20000)
            check_eq("run_to_reach", last_f * 10000 + last_y * 100 + last_x, f * 10000 + y * 100 + x);
    endtask

    task automatic check_all_zero(input string pfx);
        check_eq({pfx, "_x"}, o_x, 0);
        check_eq({pfx, "_y"}, o_y, 0);
        check_eq({pfx, "_de"}, o_de, 0);
        check_eq({pfx, "_frame"}, o_frame, 0);
        check_eq({pfx, "_locked"}, o_locked, 0);
        check_eq({pfx, "_h_total"}, o_h_total, 0);
        check_eq({pfx, "_v_total"}, o_v_total, 0);
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; hs = ~POL; vs = ~POL;
        gf = 0; gy = 0; gx = 0;
        last_f = -1; last_y = -1; last_x = -1;
        de_cnt = 0; xy_err = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Acquisition: first hs/vs edges only anchor, lock at third vs edge
        run_to(0, 0, 0); check_eq("h_total_first_edge", o_h_total, 0);
        run_to(0, 0, 1); check_eq("v_total_first_edge", o_v_total, 0);
        run_to(0, 1, 0); check_eq("h_total_second_edge", o_h_total, HT);
        run_to(1, 0, 1); check_eq("acq_locked_vs2", o_locked, 0);
        check_eq("v_total_vs2", o_v_total, VT);
        check_eq("frame_unlocked", o_frame, 0);
        run_to(2, 0, 0); check_eq("acq_locked_pre_vs3", o_locked, 0);
        run_to(2, 0, 1); check_eq("locked_vs3", o_locked, 1);
        check_eq("h_total_locked", o_h_total, HT);
        de_cnt = 0;
        run_to(3, 0, 0); check_eq("de_count_frame2", de_cnt, HA * VA);

        // Coincident hs/vs edge: clear wins, frame of 13 raster lines measures 12
        run_to(4, 0, 0); check_eq("coinc_v_total", o_v_total, VT);
        check_eq("coinc_locked", o_locked, 1);
        check_eq("coinc_frame", o_frame, 1);
        @(negedge clk); check_eq("frame_pulse_width", o_frame, 0);
        de_cnt = 0;
        run_to(4, 3, 4);  check_eq("pre_first_de", o_de, 0);
        run_to(4, 3, 5);  check_eq("first_de", o_de, 1);
        check_eq("first_x", o_x, 0);
        check_eq("first_y", o_y, 0);
        run_to(4, 8, 16); check_eq("last_de", o_de, 1);
        check_eq("last_x", o_x, HA - 1);
        check_eq("last_y", o_y, VA - 1);
        run_to(4, 8, 17); check_eq("post_last_de", o_de, 0);
        run_to(5, 0, 1);  check_eq("de_count_frame4", de_cnt, HA * VA);
        check_eq("after_coinc_v_total", o_v_total, VT);
        check_eq("after_coinc_locked", o_locked, 1);
        check_eq("frame_pulse_locked", o_frame, 1);

        // Short line drops lock at its closing hs edge
        run_to(5, 5, 18); check_eq("short_pre_locked", o_locked, 1);
        run_to(5, 6, 0);  check_eq("short_locked", o_locked, 0);
        check_eq("short_h_total", o_h_total, HT - 1);
        check_eq("short_v_total_kept", o_v_total, VT);
        run_to(5, 6, 5);  check_eq("short_de", o_de, 0);
        run_to(6, 0, 1);  check_eq("relock_vs1", o_locked, 0);
        check_eq("relock_h_total", o_h_total, HT);
        run_to(7, 0, 1);  check_eq("relock_vs2", o_locked, 0);
        run_to(8, 0, 1);  check_eq("relock_vs3", o_locked, 1);

        // Lost hsync: unlock when h_pos reaches 2*H_TOTAL
        run_to(8, 4, 19); check_eq("lost_pre_locked", o_locked, 1);
        run_to(8, 5, 0);  check_eq("lost_locked", o_locked, 0);
        check_eq("lost_de", o_de, 0);
        run_to(8, 7, 8);  check_eq("lost_de_later", o_de, 0);
        check_eq("lost_h_total_kept", o_h_total, HT);
        run_to(11, 0, 1); check_eq("relock_after_lost", o_locked, 1);

        // Reset mid-frame while locked and active
        run_to(11, 4, 8); check_eq("mid_de", o_de, 1);
        check_eq("mid_x", o_x, 3);
        check_eq("mid_y", o_y, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("rst_mid");
        rst = 1'b0;
        run_to(11, 5, 0);  check_eq("rst_h_first_edge", o_h_total, 0);
        run_to(11, 6, 0);  check_eq("rst_h_second_edge", o_h_total, HT);
        run_to(12, 0, 1);  check_eq("rst_acq_vs1", o_locked, 0);
        check_eq("rst_v_first_edge", o_v_total, 0);
        run_to(13, 0, 1);  check_eq("rst_acq_vs2", o_locked, 0);
        check_eq("rst_v_total", o_v_total, VT);
        run_to(14, 0, 1);  check_eq("rst_relock", o_locked, 1);

        check_eq("de_position_errors", xy_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
